imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the pipelined CPU's instruction memory. It accepts a byte stream (length header, payload, XOR checksum) and assembles big-endian 32-bit words. It writes them sequentially into instruction memory, then releases the CPU from reset. While loading, the CPU is held in reset. A checksum or length failure leaves the CPU halted and flags an error.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } ld_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage : imem_loader_pkg

// File: rtl/imem_loader.sv
// Boot loader: byte stream (BE length, payload, XOR checksum) -> sequential 32-bit imem writes, then CPU release.
// Latency: write strobe one cycle after the edge accepting a word's 4th byte; cpu_run_out on the checksum edge.
// Backpressure: none inside receive states (ready tracks state only); ready low in DONE/ERROR until start_in.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 16
) (
    input  logic        CLK_IN,
    input  logic        GLOBALRESET,
    input  logic        start_in,
    input  logic        rx_valid_in,
    input  logic [7:0]  rx_data_in,
    output logic        rx_ready_out,
    output logic        imem_we_out,
    output logic [31:0] imem_addr_out,
    output logic [31:0] imem_data_out,
    output logic        cpu_run_out,
    output logic        busy_out,
    output logic        error_out
);

    localparam int ASM_W = 8 * (WORD_BYTES - 1);

    ld_state_t          state_q, state_d;
    logic [7:0]         len_hi_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   idx_q;
    logic [1:0]         byte_cnt_q;
    logic [ASM_W-1:0]   asm_q;
    logic [7:0]         xor_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        data_q;

    logic               rx_fire;
    logic [8*HDR_BYTES-1:0] hdr_len;
    logic [31:0]        asm_next;
    logic               last_byte;
    logic               last_word;

    assign rx_fire   = rx_valid_in & rx_ready_out;
    assign hdr_len   = {len_hi_q, rx_data_in};
    assign asm_next  = {asm_q, rx_data_in};
    assign last_byte = (byte_cnt_q == 2'(WORD_BYTES - 1));
    assign last_word = (idx_q == (len_q - CNT_W'(1)));

    always_ff @(posedge CLK_IN or negedge GLOBALRESET) begin
        if (!GLOBALRESET) begin
            state_q <= LEN_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rx_ready_out = 1'b0;
        busy_out     = 1'b0;
        cpu_run_out  = 1'b0;
        error_out    = 1'b0;
        case (state_q)
            LEN_HI: begin
                rx_ready_out = 1'b1;
                busy_out     = 1'b1;
                if (rx_fire) state_d = LEN_LO;
            end
            LEN_LO: begin
                rx_ready_out = 1'b1;
                busy_out     = 1'b1;
                if (rx_fire) begin
                    if (int'(hdr_len) > MAX_WORDS) state_d = ERROR;
                    else if (hdr_len == '0)        state_d = CHECK;
                    else                           state_d = DATA;
                end
            end
            DATA: begin
                rx_ready_out = 1'b1;
                busy_out     = 1'b1;
                if (rx_fire && last_byte && last_word) state_d = CHECK;
            end
            CHECK: begin
                rx_ready_out = 1'b1;
                busy_out     = 1'b1;
                if (rx_fire) state_d = (rx_data_in == xor_q) ? DONE : ERROR;
            end
            DONE: begin
                cpu_run_out = 1'b1;
                if (start_in) state_d = LEN_HI;
            end
            ERROR: begin
                error_out = 1'b1;
                if (start_in) state_d = LEN_HI;
            end
            default: state_d = LEN_HI;
        endcase
    end

    // Address/data stay on the bus between strobes; only the strobe is a pulse.
    always_ff @(posedge CLK_IN or negedge GLOBALRESET) begin
        if (!GLOBALRESET) begin
            len_hi_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            xor_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            we_q <= 1'b0;
            if (rx_fire) xor_q <= xor_q ^ rx_data_in;
            case (state_q)
                LEN_HI: if (rx_fire) len_hi_q <= rx_data_in;
                LEN_LO: if (rx_fire) len_q <= CNT_W'(hdr_len);
                DATA: begin
                    if (rx_fire) begin
                        asm_q      <= asm_next[ASM_W-1:0];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (last_byte) begin
                            we_q   <= 1'b1;
                            data_q <= asm_next;
                            addr_q <= 32'({idx_q, 2'b00});
                            idx_q  <= idx_q + CNT_W'(1);
                        end
                    end
                end
                DONE, ERROR: begin
                    if (start_in) begin
                        idx_q      <= '0;
                        xor_q      <= '0;
                        byte_cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_we_out   = we_q;
    assign imem_addr_out = addr_q;
    assign imem_data_out = data_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

    localparam int MAX_WORDS = 256;
    localparam int CNT_W     = 16;

    logic        CLK_IN = 1'b0;
    logic        GLOBALRESET = 1'b0;
    logic        start_in = 1'b0;
    logic        rx_valid_in = 1'b0;
    logic [7:0]  rx_data_in = 8'h00;
    logic        rx_ready_out;
    logic        imem_we_out;
    logic [31:0] imem_addr_out;
    logic [31:0] imem_data_out;
    logic        cpu_run_out;
    logic        busy_out;
    logic        error_out;

    imem_loader #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
        .CLK_IN        (CLK_IN),
        .GLOBALRESET   (GLOBALRESET),
        .start_in      (start_in),
        .rx_valid_in   (rx_valid_in),
        .rx_data_in    (rx_data_in),
        .rx_ready_out  (rx_ready_out),
        .imem_we_out   (imem_we_out),
        .imem_addr_out (imem_addr_out),
        .imem_data_out (imem_data_out),
        .cpu_run_out   (cpu_run_out),
        .busy_out      (busy_out),
        .error_out     (error_out)
    );

    always #5 CLK_IN = ~CLK_IN;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit need_start = 1'b0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];

    always @(posedge CLK_IN) cyc <= cyc + 1;

    always @(negedge CLK_IN) begin
        if (imem_we_out === 1'b1) begin
            log_addr.push_back(imem_addr_out);
            log_data.push_back(imem_data_out);
            log_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ready"}, 32'(rx_ready_out), 32'd1);
        chk({tag, " busy"},  32'(busy_out),     32'd1);
        chk({tag, " we"},    32'(imem_we_out),  32'd0);
        chk({tag, " addr"},  imem_addr_out,     32'd0);
        chk({tag, " data"},  imem_data_out,     32'd0);
        chk({tag, " run"},   32'(cpu_run_out),  32'd0);
        chk({tag, " err"},   32'(error_out),    32'd0);
    endtask

    task automatic do_start();
        start_in = 1'b1;
        @(posedge CLK_IN); #1;
        start_in = 1'b0;
        need_start = 1'b0;
    endtask

    // Gaps carry random start_in pulses, which must be ignored while receiving.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                rx_valid_in = 1'b0;
                start_in    = 1'($urandom_range(0, 1));
                @(posedge CLK_IN); #1;
                start_in    = 1'b0;
            end
        end
        rx_valid_in = 1'b1;
        rx_data_in  = b;
        @(posedge CLK_IN); #1;
        rx_valid_in = 1'b0;
    endtask

    task automatic build_stream(input int n, input logic [31:0] words[$], input bit corrupt,
                                output logic [7:0] bytes[$]);
        logic [7:0] x;
        bytes.delete();
        bytes.push_back(8'(n >> 8));
        bytes.push_back(8'(n));
        if (n <= MAX_WORDS) begin
            foreach (words[i]) begin
                bytes.push_back(words[i][31:24]);
                bytes.push_back(words[i][23:16]);
                bytes.push_back(words[i][15:8]);
                bytes.push_back(words[i][7:0]);
            end
            x = 8'h00;
            foreach (bytes[i]) x ^= bytes[i];
            bytes.push_back(corrupt ? (x ^ 8'h01) : x);
        end
    endtask

    task automatic run_load(input string tag, input int n, input logic [31:0] words[$],
                            input bit corrupt, input bit gaps);
        logic [7:0] bytes[$];
        int  ne;
        bit  ok;
        if (need_start) do_start();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        build_stream(n, words, corrupt, bytes);
        foreach (bytes[i]) send_byte(bytes[i], gaps);
        @(negedge CLK_IN);
        ok = (n <= MAX_WORDS) && !corrupt;
        ne = (n <= MAX_WORDS) ? n : 0;
        chk({tag, " nwrites"}, 32'(log_addr.size()), 32'(ne));
        for (int i = 0; i < ne && i < log_addr.size(); i++) begin
            chk($sformatf("%s addr%0d", tag, i), log_addr[i], 32'(i * 4));
            chk($sformatf("%s data%0d", tag, i), log_data[i], words[i]);
        end
        chk({tag, " run"},   32'(cpu_run_out),  32'(ok));
        chk({tag, " err"},   32'(error_out),    32'(!ok));
        chk({tag, " busy"},  32'(busy_out),     32'd0);
        chk({tag, " ready"}, 32'(rx_ready_out), 32'd0);
        need_start = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w[$];
        logic [7:0]  bytes[$];
        int          n;
        bit          corrupt;

        repeat (2) @(posedge CLK_IN);
        #1;
        chk_reset_outputs("reset");
        GLOBALRESET = 1'b1;
        @(posedge CLK_IN); #1;

        w = '{32'h20020005};
        run_load("n1", 1, w, 1'b0, 1'b0);

        w = '{32'h8C010000, 32'hAC010004};
        run_load("n2gaps", 2, w, 1'b0, 1'b1);

        w.delete();
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        run_load("b2b", 3, w, 1'b0, 1'b0);
        for (int i = 1; i < log_cyc.size(); i++)
            chk($sformatf("b2b spacing%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 32'd4);

        w.delete();
        run_load("n257", MAX_WORDS + 1, w, 1'b0, 1'b0);

        w = '{$urandom};
        run_load("badsum", 1, w, 1'b1, 1'b0);
        do_start();
        chk("badsum restart busy", 32'(busy_out),  32'd1);
        chk("badsum restart err",  32'(error_out), 32'd0);

        w.delete();
        run_load("n0", 0, w, 1'b0, 1'b0);
        do_start();
        chk("n0 restart run",  32'(cpu_run_out), 32'd0);
        chk("n0 restart busy", 32'(busy_out),    32'd1);

        // Reset in the middle of a word: partial state must vanish.
        w = '{32'hDEADBEEF};
        build_stream(1, w, 1'b0, bytes);
        for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b0);
        #2;
        GLOBALRESET = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge CLK_IN); #1;
        GLOBALRESET = 1'b1;
        need_start = 1'b0;
        w = '{$urandom};
        run_load("afterrst", 1, w, 1'b0, 1'b1);

        w.delete();
        for (int i = 0; i < MAX_WORDS; i++) w.push_back($urandom);
        run_load("nmax", MAX_WORDS, w, 1'b0, 1'b0);

        for (int t = 0; t < 14; t++) begin
            w.delete();
            if ($urandom_range(0, 7) == 0) n = MAX_WORDS + 1 + int'($urandom_range(0, 300));
            else                           n = int'($urandom_range(0, 6));
            if (n <= MAX_WORDS) for (int i = 0; i < n; i++) w.push_back($urandom);
            corrupt = ($urandom_range(0, 3) == 0);
            run_load($sformatf("rnd%0d", t), n, w, corrupt, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_imem_loader
